// File: rtl/c17_resp_misr.sv
// rtl/c17_resp_misr.sv - c17 N22/N23 response MISR over an NPAT-pattern session
// Optional golden-signature comparator is built when C17_MISR_CMP_EN is defined.
module c17_resp_misr #(
    parameter int             W      = 8,
    parameter logic [W-1:0]   POLY   = W'(8'h1D),
    parameter logic [W-1:0]   SEED   = '0,
    parameter int             NPAT   = 32,
    parameter logic [W-1:0]   GOLDEN = '0,
    localparam int            CW     = $clog2(NPAT + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          valid,
    input  logic          n22,
    input  logic          n23,
    output logic          busy,
    output logic          done,
    output logic [W-1:0]  sig,
    output logic [CW-1:0] pcnt,
    output logic          pass
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t        state, state_next;
    logic [W-1:0]  sig_next;
    logic [CW-1:0] pcnt_next;
    logic [W-1:0]  resp;
    logic [W-1:0]  fold;
    logic          absorb;
    logic          last;

    // Responses land in the two low bits; upper bits of the injection word are zero.
    always_comb begin
        resp      = '0;
        resp[1:0] = {n23, n22};
        fold      = {sig[W-2:0], 1'b0} ^ (sig[W-1] ? POLY : '0) ^ resp;
    end

    always_comb begin
        state_next = state;
        sig_next   = sig;
        pcnt_next  = pcnt;
        absorb     = 1'b0;
        last       = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_next = S_RUN;
                    sig_next   = SEED;
                    pcnt_next  = '0;
                end
            end
            S_RUN: begin
                if (valid) begin
                    absorb    = 1'b1;
                    sig_next  = fold;
                    pcnt_next = pcnt + CW'(1);
                    if (pcnt == CW'(NPAT - 1)) begin
                        last       = 1'b1;
                        state_next = S_DONE;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            sig   <= '0;
            pcnt  <= '0;
        end else begin
            state <= state_next;
            sig   <= sig_next;
            pcnt  <= pcnt_next;
        end
    end

    assign busy = (state == S_RUN);
    assign done = (state == S_DONE);

`ifdef C17_MISR_CMP_EN
    logic pass_q;

    // Verdict is taken from the signature being written on the completing edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pass_q <= 1'b0;
        end else if (last) begin
            pass_q <= (fold == GOLDEN);
        end else if (state_next == S_RUN && state != S_RUN) begin
            pass_q <= 1'b0;
        end
    end

    assign pass = pass_q;
`else
    assign pass = 1'b0;
`endif

    logic unused_absorb;
    assign unused_absorb = absorb;

endmodule

// File: tb/tb_c17_resp_misr.sv
// tb/tb_c17_resp_misr.sv - randomized and directed bench for c17_resp_misr
module tb_c17_resp_misr;

    logic clk, rst, start, valid, n22, n23;
    logic [7:0] sg [3];
    logic       bz [3];
    logic       dn [3];
    logic       ps [3];
    logic [3:0] pc [3];
    logic [2:0] p0, p1;
    logic [3:0] p2;

    int checks = 0;
    int errors = 0;

    int         npat [3] = '{4, 4, 9};
    logic [7:0] gold [3] = '{8'h11, 8'h12, 8'hE2};
    int         mmode [3];
    logic [7:0] msig [3];
    int         mcnt [3];
    bit         mpass [3];

    c17_resp_misr #(.W(8), .POLY(8'h1D), .SEED(8'h00), .NPAT(4), .GOLDEN(8'h11)) u0 (
        .clk(clk), .rst(rst), .start(start), .valid(valid), .n22(n22), .n23(n23),
        .busy(bz[0]), .done(dn[0]), .sig(sg[0]), .pcnt(p0), .pass(ps[0]));
    c17_resp_misr #(.W(8), .POLY(8'h1D), .SEED(8'h00), .NPAT(4), .GOLDEN(8'h12)) u1 (
        .clk(clk), .rst(rst), .start(start), .valid(valid), .n22(n22), .n23(n23),
        .busy(bz[1]), .done(dn[1]), .sig(sg[1]), .pcnt(p1), .pass(ps[1]));
    c17_resp_misr #(.W(8), .POLY(8'h1D), .SEED(8'h00), .NPAT(9), .GOLDEN(8'hE2)) u2 (
        .clk(clk), .rst(rst), .start(start), .valid(valid), .n22(n22), .n23(n23),
        .busy(bz[2]), .done(dn[2]), .sig(sg[2]), .pcnt(p2), .pass(ps[2]));

    assign pc[0] = {1'b0, p0};
    assign pc[1] = {1'b0, p1};
    assign pc[2] = p2;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required finish earlier");
        $fatal(1, "watchdog");
    end

    // Signature step as polynomial arithmetic over GF(2): multiply by x, reduce by x^8+x^4+x^3+x^2+1, add response.
    function automatic logic [7:0] ref_step(logic [7:0] s, logic a, logic b);
        int t;
        t = int'(s) * 2;
        if (t >= 256) t = t ^ 'h11D;
        t = t ^ (int'(b) * 2 + int'(a));
        return t[7:0];
    endfunction

    function automatic bit exp_pass(int i);
`ifdef C17_MISR_CMP_EN
        return mpass[i];
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit cmp_on();
`ifdef C17_MISR_CMP_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            mmode[i] = 0; msig[i] = 8'h00; mcnt[i] = 0; mpass[i] = 1'b0;
        end
    endtask

    // Session-level model: 0 = idle, 1 = collecting, 2 = holding a finished signature.
    task automatic model_edge(logic st, logic v, logic a, logic b);
        for (int i = 0; i < 3; i++) begin
            if (mmode[i] == 1) begin
                if (v) begin
                    msig[i] = ref_step(msig[i], a, b);
                    mcnt[i]++;
                    if (mcnt[i] == npat[i]) begin
                        mmode[i] = 2;
                        mpass[i] = (msig[i] == gold[i]);
                    end
                end
            end else if (st) begin
                mmode[i] = 1; msig[i] = 8'h00; mcnt[i] = 0; mpass[i] = 1'b0;
            end
        end
    endtask

    task automatic cycle(logic st, logic v, logic a, logic b);
        start = st; valid = v; n22 = a; n23 = b;
        @(posedge clk);
        #1;
        model_edge(st, v, a, b);
        start = 1'b0;
    endtask

    task automatic do_reset();
        start = 1'b0; valid = 1'b0; n22 = 1'b0; n23 = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        for (int c = 0; c < 6; c++) begin
            cycle(1'b0, 1'(c % 2), 1'b1, 1'b1);
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (sg[i] !== 8'h00 || pc[i] !== 4'd0 || bz[i] !== 1'b0 || dn[i] !== 1'b0 || ps[i] !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_idle u%0d c%0d: sig=%h pcnt=%0d busy=%b done=%b pass=%b, required all zero",
                             i, c, sg[i], pc[i], bz[i], dn[i], ps[i]);
                end
            end
        end
    endtask

    task automatic test_zero();
        do_reset();
        cycle(1'b1, 1'b1, 1'b1, 1'b1);
        checks++;
        if (bz[0] !== 1'b1 || sg[0] !== 8'h00 || pc[0] !== 4'd0) begin
            errors++;
            $display("FAIL zero_start: busy=%b sig=%h pcnt=%0d, required busy=1 sig=00 pcnt=0", bz[0], sg[0], pc[0]);
        end
        for (int c = 1; c <= 4; c++) begin
            cycle(1'b0, 1'b1, 1'b0, 1'b0);
            checks++;
            if (dn[0] !== (c == 4)) begin
                errors++;
                $display("FAIL zero_done_timing c%0d: done=%b, required %b", c, dn[0], (c == 4));
            end
        end
        checks++;
        if (sg[0] !== 8'h00 || pc[0] !== 4'd4 || bz[0] !== 1'b0) begin
            errors++;
            $display("FAIL zero_final: sig=%h pcnt=%0d busy=%b, required sig=00 pcnt=4 busy=0", sg[0], pc[0], bz[0]);
        end
    endtask

    task automatic test_ones();
        logic [7:0] seq [4] = '{8'h03, 8'h05, 8'h09, 8'h11};
        do_reset();
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 4; c++) begin
            cycle(1'b0, 1'b1, 1'b1, 1'b1);
            checks++;
            if (sg[0] !== seq[c]) begin
                errors++;
                $display("FAIL ones_seq c%0d: sig=%h, required %h", c, sg[0], seq[c]);
            end
        end
        checks++;
        if (dn[0] !== 1'b1 || ps[0] !== cmp_on() || ps[1] !== 1'b0) begin
            errors++;
            $display("FAIL ones_pass: done=%b pass11=%b pass12=%b, required done=1 pass11=%b pass12=0",
                     dn[0], ps[0], ps[1], cmp_on());
        end
    endtask

    task automatic test_wrap();
        do_reset();
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        for (int c = 1; c <= 9; c++) begin
            cycle(1'b0, 1'b1, 1'b1, 1'b0);
            if (c == 8) begin
                checks++;
                if (sg[2] !== 8'hFF || dn[2] !== 1'b0) begin
                    errors++;
                    $display("FAIL wrap_8: sig=%h done=%b, required FF 0", sg[2], dn[2]);
                end
            end
        end
        checks++;
        if (sg[2] !== 8'hE2 || dn[2] !== 1'b1 || pc[2] !== 4'd9) begin
            errors++;
            $display("FAIL wrap_final: sig=%h done=%b pcnt=%0d, required E2 1 9", sg[2], dn[2], pc[2]);
        end
        checks++;
        if (sg[0] !== 8'h0F || pc[0] !== 4'd4 || dn[0] !== 1'b1) begin
            errors++;
            $display("FAIL freeze_after_done: sig=%h pcnt=%0d done=%b, required 0F 4 1", sg[0], pc[0], dn[0]);
        end
    endtask

    task automatic test_gaps();
        logic vp [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        do_reset();
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 7; c++) begin
            cycle((c == 2 || c == 6), vp[c], 1'b1, 1'b1);
            checks++;
            if (dn[0] !== (c == 6)) begin
                errors++;
                $display("FAIL gaps_done c%0d: done=%b, required %b", c, dn[0], (c == 6));
            end
        end
        checks++;
        if (sg[0] !== 8'h11 || pc[0] !== 4'd4 || bz[0] !== 1'b0) begin
            errors++;
            $display("FAIL gaps_final: sig=%h pcnt=%0d busy=%b, required 11 4 0", sg[0], pc[0], bz[0]);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 1'b1);
        cycle(1'b0, 1'b1, 1'b1, 1'b1);
        checks++;
        if (pc[0] !== 4'd2 || bz[0] !== 1'b1) begin
            errors++;
            $display("FAIL arst_pre: pcnt=%0d busy=%b, required 2 1", pc[0], bz[0]);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bz[0] !== 1'b0 || sg[0] !== 8'h00 || pc[0] !== 4'd0 || dn[0] !== 1'b0) begin
            errors++;
            $display("FAIL arst_immediate: busy=%b sig=%h pcnt=%0d done=%b, required all zero", bz[0], sg[0], pc[0], dn[0]);
        end
        #1 rst = 1'b0;
        model_reset();
        cycle(1'b0, 1'b1, 1'b1, 1'b1);
        checks++;
        if (bz[0] !== 1'b0 || pc[0] !== 4'd0) begin
            errors++;
            $display("FAIL arst_no_resume: busy=%b pcnt=%0d, required 0 0", bz[0], pc[0]);
        end
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        for (int c = 1; c <= 4; c++) begin
            cycle(1'b0, 1'b1, 1'b1, 1'b1);
            checks++;
            if (dn[0] !== (c == 4)) begin
                errors++;
                $display("FAIL arst_session c%0d: done=%b, required %b", c, dn[0], (c == 4));
            end
        end
        checks++;
        if (sg[0] !== 8'h11) begin
            errors++;
            $display("FAIL arst_sig: sig=%h, required 11", sg[0]);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            cycle(($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0),
                  1'($urandom), 1'($urandom));
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (sg[i] !== msig[i] || pc[i] !== 4'(mcnt[i]) || bz[i] !== (mmode[i] == 1) ||
                    dn[i] !== (mmode[i] == 2) || ps[i] !== exp_pass(i)) begin
                    errors++;
                    $display("FAIL random u%0d c%0d: sig=%h pcnt=%0d busy=%b done=%b pass=%b, required %h %0d %b %b %b",
                             i, c, sg[i], pc[i], bz[i], dn[i], ps[i],
                             msig[i], mcnt[i], (mmode[i] == 1), (mmode[i] == 2), exp_pass(i));
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; valid = 1'b0; n22 = 1'b0; n23 = 1'b0;
        model_reset();
        test_reset();
        test_zero();
        test_ones();
        test_wrap();
        test_gaps();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
